// File: rtl/pe_pool_seq_ctrl.sv
// Sequencer for one PE_POOL job: loads T weights, streams W windows of T activation beats, then POOL_FIN.
// Packet outputs are registered, so a beat accepted at an edge is on the packet in the following cycle.
module pe_pool_seq_ctrl #(
    parameter int DATA_WID = 8,
    parameter int ICP_NUM  = 4,
    parameter int ADDR_B   = 4,
    parameter int CAP_B    = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_B-1:0]           taps_cfg,
    input  logic [3:0]                  win_cfg,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [DATA_WID-1:0]         w_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ICP_NUM*DATA_WID-1:0] a_data,
    output logic [1:0]                  pe_state,
    output logic [ICP_NUM*DATA_WID-1:0] pe_a,
    output logic [DATA_WID-1:0]         wrb_data,
    output logic [ADDR_B-1:0]           wrb_addr,
    output logic [ICP_NUM-1:0]          wrb,
    output logic [ADDR_B-1:0]           rdb_addr,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_POOL,
        S_DONE
    } state_t;

    localparam logic [1:0] PK_INVALID  = 2'd0;
    localparam logic [1:0] PK_VALID    = 2'd1;
    localparam logic [1:0] PK_CNN_FIN  = 2'd2;
    localparam logic [1:0] PK_POOL_FIN = 2'd3;
    localparam logic [ADDR_B-1:0] CAP_V = ADDR_B'(CAP_B);

    state_t                      state, state_nxt;
    logic [ADDR_B-1:0]           taps_r, taps_nxt, taps_sat, t_last;
    logic [ADDR_B-1:0]           wcnt, wcnt_nxt, tap, tap_nxt;
    logic [3:0]                  wins_r, wins_nxt, win, win_nxt;
    logic [1:0]                  pe_state_nxt;
    logic [ICP_NUM*DATA_WID-1:0] pe_a_nxt;
    logic [DATA_WID-1:0]         wrb_data_nxt;
    logic [ADDR_B-1:0]           wrb_addr_nxt, rdb_addr_nxt;
    logic [ICP_NUM-1:0]          wrb_nxt;
    logic                        done_nxt;
    logic                        w_acc, a_acc;

    // Handshake readies come straight from the state register, so they switch on the same edge as the state.
    assign w_ready  = (state == S_LOAD_W);
    assign a_ready  = (state == S_STREAM);
    assign busy     = (state != S_IDLE);
    assign w_acc    = w_valid && w_ready;
    assign a_acc    = a_valid && a_ready;
    assign t_last   = taps_r - ADDR_B'(1);
    assign taps_sat = (taps_cfg == '0)   ? ADDR_B'(1) :
                      (taps_cfg > CAP_V) ? CAP_V      : taps_cfg;

    always_comb begin
        state_nxt    = state;
        taps_nxt     = taps_r;
        wins_nxt     = wins_r;
        wcnt_nxt     = wcnt;
        tap_nxt      = tap;
        win_nxt      = win;
        pe_state_nxt = PK_INVALID;
        pe_a_nxt     = '0;
        wrb_nxt      = '0;
        wrb_data_nxt = wrb_data;
        wrb_addr_nxt = wrb_addr;
        rdb_addr_nxt = rdb_addr;
        done_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    taps_nxt  = taps_sat;
                    wins_nxt  = (win_cfg == 4'd0) ? 4'd1 : win_cfg;
                    wcnt_nxt  = '0;
                    tap_nxt   = '0;
                    win_nxt   = '0;
                    state_nxt = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_acc) begin
                    wrb_nxt      = '1;
                    wrb_data_nxt = w_data;
                    wrb_addr_nxt = wcnt;
                    if (wcnt == t_last) begin
                        wcnt_nxt  = '0;
                        state_nxt = S_STREAM;
                    end else begin
                        wcnt_nxt = wcnt + ADDR_B'(1);
                    end
                end
            end
            S_STREAM: begin
                if (a_acc) begin
                    pe_a_nxt     = a_data;
                    rdb_addr_nxt = tap;
                    if (tap == t_last) begin
                        pe_state_nxt = PK_CNN_FIN;
                        tap_nxt      = '0;
                        // Closing the last window ends streaming; a_ready drops on this edge.
                        if (win == wins_r - 4'd1) begin
                            win_nxt   = '0;
                            state_nxt = S_POOL;
                        end else begin
                            win_nxt = win + 4'd1;
                        end
                    end else begin
                        pe_state_nxt = PK_VALID;
                        tap_nxt      = tap + ADDR_B'(1);
                    end
                end
            end
            S_POOL: begin
                pe_state_nxt = PK_POOL_FIN;
                rdb_addr_nxt = '0;
                state_nxt    = S_DONE;
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            taps_r   <= '0;
            wins_r   <= '0;
            wcnt     <= '0;
            tap      <= '0;
            win      <= '0;
            pe_state <= PK_INVALID;
            pe_a     <= '0;
            wrb      <= '0;
            wrb_data <= '0;
            wrb_addr <= '0;
            rdb_addr <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            taps_r   <= taps_nxt;
            wins_r   <= wins_nxt;
            wcnt     <= wcnt_nxt;
            tap      <= tap_nxt;
            win      <= win_nxt;
            pe_state <= pe_state_nxt;
            pe_a     <= pe_a_nxt;
            wrb      <= wrb_nxt;
            wrb_data <= wrb_data_nxt;
            wrb_addr <= wrb_addr_nxt;
            rdb_addr <= rdb_addr_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pe_pool_seq_ctrl.sv
// Bench for pe_pool_seq_ctrl: table of job configs driven with random stalls against a transaction-level model.
module tb_pe_pool_seq_ctrl;
    localparam int DW  = 8;
    localparam int ICP = 4;
    localparam int AB  = 4;
    localparam int CAP = 9;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [AB-1:0]     taps_cfg;
    logic [3:0]        win_cfg;
    logic              w_valid, w_ready, a_valid, a_ready;
    logic [DW-1:0]     w_data, wrb_data;
    logic [ICP*DW-1:0] a_data, pe_a;
    logic [1:0]        pe_state;
    logic [AB-1:0]     wrb_addr, rdb_addr;
    logic [ICP-1:0]    wrb;
    logic              busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_pool_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .taps_cfg(taps_cfg), .win_cfg(win_cfg),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .pe_state(pe_state), .pe_a(pe_a), .wrb_data(wrb_data), .wrb_addr(wrb_addr),
        .wrb(wrb), .rdb_addr(rdb_addr), .busy(busy), .done(done)
    );

    typedef struct {
        logic [3:0] tc;
        logic [3:0] wc;
        int         stall;
        bit         det;
        bit         mid;
        bit         abrt;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_taps(input logic [3:0] tc);
        if (tc == 0) return 1;
        if (int'(tc) > CAP) return CAP;
        return int'(tc);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pe_state"}, 64'(pe_state), 0);
        chk({tag, "_pe_a"}, 64'(pe_a), 0);
        chk({tag, "_wrb"}, 64'(wrb), 0);
        chk({tag, "_wrb_data"}, 64'(wrb_data), 0);
        chk({tag, "_wrb_addr"}, 64'(wrb_addr), 0);
        chk({tag, "_rdb_addr"}, 64'(rdb_addr), 0);
        chk({tag, "_w_ready"}, 64'(w_ready), 0);
        chk({tag, "_a_ready"}, 64'(a_ready), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    // Model view of a job: T weight writes, then W*T beats whose tap is the beat index mod T,
    // then one POOL_FIN cycle, then the done pulse with busy low.
    task automatic run_job(input vec_t v);
        int T, W, nw, ns, post, cyc, k;
        bit pw, pa, exp_wr, exp_ar;
        logic [DW-1:0]     pwd;
        logic [ICP*DW-1:0] pad;
        T = eff_taps(v.tc);
        W = (v.wc == 0) ? 1 : int'(v.wc);
        @(negedge clk);
        start = 1'b1; taps_cfg = v.tc; win_cfg = v.wc; w_valid = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nw = 0; ns = 0; post = 0; cyc = 0; pw = 1'b0; pa = 1'b0; pwd = '0; pad = '0;
        forever begin
            if (pw) begin
                chk("wr_en", 64'(wrb), 64'hf);
                chk("wr_addr", 64'(wrb_addr), 64'(nw));
                chk("wr_data", 64'(wrb_data), 64'(pwd));
                chk("wr_state", 64'(pe_state), 0);
                nw++;
            end else if (pa) begin
                k = ns % T;
                chk("beat_state", 64'(pe_state), (k == T - 1) ? 2 : 1);
                chk("beat_rdb", 64'(rdb_addr), 64'(k));
                chk("beat_a", 64'(pe_a), 64'(pad));
                chk("beat_wrb", 64'(wrb), 0);
                ns++;
            end else begin
                if (ns == W * T) post++;
                chk("idle_state", 64'(pe_state), (post == 1) ? 3 : 0);
                chk("idle_wrb", 64'(wrb), 0);
                chk("idle_pe_a", 64'(pe_a), 0);
                if (post == 1) chk("pool_rdb", 64'(rdb_addr), 0);
            end
            chk("done", 64'(done), (post == 2) ? 1 : 0);
            chk("busy", 64'(busy), (post < 2) ? 1 : 0);
            exp_wr = (nw < T);
            exp_ar = (nw == T) && (ns < W * T);
            chk("w_ready", 64'(w_ready), 64'(exp_wr));
            chk("a_ready", 64'(a_ready), 64'(exp_ar));
            if (post == 2) break;
            if (v.abrt && nw == T && ns == 3) begin
                reset = 1'b0; w_valid = 1'b0; a_valid = 1'b1;
                @(negedge clk);
                chk_all_zero("abort");
                reset = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("post_abort_state", 64'(pe_state), 0);
                    chk("post_abort_done", 64'(done), 0);
                    chk("post_abort_busy", 64'(busy), 0);
                end
                a_valid = 1'b0;
                return;
            end
            if (cyc > 3000) begin
                chk("job_timeout", 64'(cyc), 64'(v.exp_cyc));
                return;
            end
            start    = v.mid && (nw == T) && (ns == 1);
            taps_cfg = start ? 4'd1 : v.tc;
            w_valid  = ($urandom_range(99) >= v.stall);
            a_valid  = ($urandom_range(99) >= v.stall);
            w_data   = v.det ? DW'(nw + 1) : DW'($urandom);
            a_data   = v.det ? {DW'(30 + ns), DW'(20 + ns), DW'(10 + ns), DW'(ns)} : $urandom;
            pw  = w_valid && exp_wr;
            pa  = a_valid && exp_ar;
            pwd = w_data;
            pad = a_data;
            @(negedge clk);
            cyc++;
        end
        if (v.exp_cyc >= 0) chk("job_cycles", 64'(cyc), 64'(v.exp_cyc));
        w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("done_single", 64'(done), 0);
        chk("end_busy", 64'(busy), 0);
    endtask

    initial begin
        vec_t rv;
        reset = 1'b0; start = 1'b0; taps_cfg = '0; win_cfg = '0;
        w_valid = 1'b1; a_valid = 1'b1; w_data = 8'h5a; a_data = 32'h12345678;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_w_ready", 64'(w_ready), 0);
            chk("idle_a_ready", 64'(a_ready), 0);
            chk("idle_busy", 64'(busy), 0);
            chk("idle_wrb", 64'(wrb), 0);
            chk("idle_pe_state", 64'(pe_state), 0);
        end
        w_valid = 1'b0; a_valid = 1'b0;

        vecs[0] = '{4'd9,  4'd1, 0,  1'b1, 1'b0, 1'b0, 20};
        vecs[1] = '{4'd4,  4'd3, 0,  1'b0, 1'b0, 1'b0, 18};
        vecs[2] = '{4'd5,  4'd2, 50, 1'b0, 1'b0, 1'b0, -1};
        vecs[3] = '{4'd0,  4'd3, 0,  1'b0, 1'b0, 1'b0, 6};
        vecs[4] = '{4'd15, 4'd1, 0,  1'b0, 1'b0, 1'b0, 20};
        vecs[5] = '{4'd3,  4'd0, 0,  1'b0, 1'b0, 1'b0, 8};
        vecs[6] = '{4'd4,  4'd2, 0,  1'b0, 1'b1, 1'b0, 14};
        vecs[7] = '{4'd6,  4'd2, 0,  1'b0, 1'b0, 1'b1, -1};
        vecs[8] = '{4'd5,  4'd2, 0,  1'b1, 1'b0, 1'b0, 17};
        for (int i = 0; i < 9; i++) run_job(vecs[i]);

        for (int j = 0; j < 4; j++) begin
            rv = '{4'($urandom_range(15)), 4'($urandom_range(15)), 30, 1'b0, 1'b0, 1'b0, -1};
            run_job(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
